msi_irq_ctrl: RTL
=================

Name: msi_irq_ctrl

Overview:
Receives message-signalled interrupts (code plus one-cycle pulse) from the tile SFR block and latches them into per-line pending bits. Applies a software-written enable mask and arbitrates among enabled pending lines, lowest code first. Presents one interrupt at a time to the CPU core with a req/ack handshake. Sits between the SFR MSI output and the core interrupt input inside sigma_tile.

Parameters:
IRQ_NUM_POW, 4, log2 of number of interrupt lines; IRQ_NUM = 2**IRQ_NUM_POW (localparam, 16 by default)
IRQ_MASK_DEFAULT, 0, reset value of enable mask (IRQ_NUM bits)

Ports:
clk_i  input  1  clock, all state on posedge
rst_ni  input  1  reset, asynchronous assert, active-low
msi_req_i  input  1  MSI strobe, single-cycle pulse from SFR
msi_code_bi  input  IRQ_NUM_POW  MSI line number, valid with msi_req_i
mask_we_i  input  1  mask write strobe
mask_wdata_bi  input  IRQ_NUM  new enable mask (1 = enabled)
mask_bo  output  IRQ_NUM  current enable mask
pending_bo  output  IRQ_NUM  current pending bits (unmasked view)
irq_req_o  output  1  interrupt request to core
irq_code_bo  output  IRQ_NUM_POW  line number of presented interrupt
irq_ack_i  input  1  core accepts presented interrupt

Behaviour:
- Reset (rst_ni low, async): pending=0, mask=IRQ_MASK_DEFAULT, irq_req_o=0, irq_code_bo=0, FSM=IDLE. Reset mid-handshake drops the request and all pending bits.
- Pending set: msi_req_i high at edge N -> pending[msi_code_bi] = 1 after edge N. MSI to an already pending line merges (no second delivery).
- Mask write: mask_we_i at edge N -> mask updated after edge N. Masking affects arbitration only; pending bits are kept while masked and are delivered once unmasked.
- FSM states IDLE, REQ, GAP:
  - IDLE: if (pending & mask) != 0, register code of lowest set bit into irq_code_bo, set irq_req_o=1, go to REQ. Otherwise stay.
  - REQ: irq_req_o and irq_code_bo held stable. On irq_ack_i: clear pending[irq_code_bo], irq_req_o=0, go to GAP. A mask change in REQ does not retract the request.
  - GAP: one idle cycle, then IDLE. This guarantees irq_req_o is low for at least one cycle between deliveries.
- Latency: MSI pulse sampled at edge N -> irq_req_o high after edge N+1 (2 cycles), provided the FSM is in IDLE and the line is enabled.
- Simultaneous set and clear: if msi_req_i targets the same line being acked in the same cycle, set wins and the line stays pending for a second delivery.
- irq_ack_i outside REQ is ignored.
- msi_code_bi is always in range (width equals IRQ_NUM_POW); no out-of-range check.

Optional Feature:
MSI_IRQ_OVF_EN: when defined, adds output ovf_bo [IRQ_NUM]. ovf_bo[i] is set by an MSI to line i while pending[i] is already 1 (merge event), including the set-wins-over-ack case. It is cleared only by reset or by input ovf_clr_i (1 bit, clears all bits; if a set and a clear hit the same edge, set wins). When not defined, ovf_bo and ovf_clr_i do not exist and merges are silent.

Test Plan:
- Reset state: release rst_ni with IRQ_MASK_DEFAULT=16'h0000 -> irq_req_o=0, pending_bo=0, mask_bo=0.
- Basic delivery: write mask 16'hFFFF, pulse MSI code 5 at edge N -> pending_bo=16'h0020 after N, irq_req_o=1 and irq_code_bo=5 after N+1. Ack -> pending_bo=0, irq_req_o low for at least 1 cycle.
- Priority: MSI codes 9, then 3, then 12 on consecutive cycles with all lines enabled -> delivered in order 3, 9, 12. If 9 was already presented before 3 arrived, order is 9, 3, 12.
- Masking: mask 16'hFFF7, MSI code 3 -> no request, pending_bo=16'h0008. Write mask 16'hFFFF -> irq_code_bo=3 two cycles later.
- Set during ack: line 7 presented; MSI code 7 in the same cycle as irq_ack_i -> line 7 is delivered a second time. With MSI_IRQ_OVF_EN, ovf_bo[7]=1.
- Async reset mid-REQ: assert rst_ni low between clock edges -> irq_req_o=0 immediately and pending_bo=0 without waiting for a clock edge.

Source files
------------

// File: rtl/msi_irq_ctrl.sv
// msi_irq_ctrl: latches MSI pulses into pending bits and presents the lowest enabled
// pending line to the core over a req/ack handshake. Define MSI_IRQ_OVF_EN for merge flags.
module msi_irq_ctrl #(
   parameter int IRQ_NUM_POW = 4,
   localparam int IRQ_NUM = 2**IRQ_NUM_POW,
   parameter logic [IRQ_NUM-1:0] IRQ_MASK_DEFAULT = '0
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   msi_req_i,
   input  logic [IRQ_NUM_POW-1:0] msi_code_bi,
   input  logic                   mask_we_i,
   input  logic [IRQ_NUM-1:0]     mask_wdata_bi,
   output logic [IRQ_NUM-1:0]     mask_bo,
   output logic [IRQ_NUM-1:0]     pending_bo,
   output logic                   irq_req_o,
   output logic [IRQ_NUM_POW-1:0] irq_code_bo,
   input  logic                   irq_ack_i
`ifdef MSI_IRQ_OVF_EN
   ,
   input  logic                   ovf_clr_i,
   output logic [IRQ_NUM-1:0]     ovf_bo
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

   state_t                 state_q, state_d;
   logic [IRQ_NUM-1:0]     pending_q, pending_d, mask_q;
   logic [IRQ_NUM-1:0]     set_vec, clr_vec, active;
   logic                   irq_req_q, irq_req_d;
   logic [IRQ_NUM_POW-1:0] irq_code_q, irq_code_d;

   // Scanning downwards leaves the lowest set index as the final assignment.
   function automatic logic [IRQ_NUM_POW-1:0] lowest_set(input logic [IRQ_NUM-1:0] v);
      lowest_set = '0;
      for (int i = IRQ_NUM-1; i >= 0; i--) begin
         if (v[i]) lowest_set = IRQ_NUM_POW'(i);
      end
   endfunction

   always_comb begin
      set_vec = '0;
      if (msi_req_i) set_vec[msi_code_bi] = 1'b1;
   end

   assign active = pending_q & mask_q;

   always_comb begin
      state_d    = state_q;
      irq_req_d  = irq_req_q;
      irq_code_d = irq_code_q;
      clr_vec    = '0;
      unique case (state_q)
         IDLE: begin
            if (active != '0) begin
               irq_code_d = lowest_set(active);
               irq_req_d  = 1'b1;
               state_d    = REQ;
            end
         end
         REQ: begin
            if (irq_ack_i) begin
               clr_vec[irq_code_q] = 1'b1;
               irq_req_d           = 1'b0;
               state_d             = GAP;
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Set is applied after clear so a new MSI to the line being acked stays pending.
   assign pending_d = (pending_q & ~clr_vec) | set_vec;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         irq_req_q  <= 1'b0;
         irq_code_q <= '0;
         pending_q  <= '0;
      end else begin
         state_q    <= state_d;
         irq_req_q  <= irq_req_d;
         irq_code_q <= irq_code_d;
         pending_q  <= pending_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)        mask_q <= IRQ_MASK_DEFAULT;
      else if (mask_we_i) mask_q <= mask_wdata_bi;
   end

`ifdef MSI_IRQ_OVF_EN
   logic [IRQ_NUM-1:0] ovf_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ovf_q <= '0;
      else         ovf_q <= (ovf_clr_i ? '0 : ovf_q) | (set_vec & pending_q);
   end

   assign ovf_bo = ovf_q;
`endif

   assign mask_bo     = mask_q;
   assign pending_bo  = pending_q;
   assign irq_req_o   = irq_req_q;
   assign irq_code_bo = irq_code_q;

endmodule
